// File: rtl/datapath_seq_pkg.sv
// Shared types and opcode constants for the datapath sequencer and its decoder.
package datapath_seq_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    CLS_MISC    = 2'b00,
    CLS_ALU_REG = 2'b01,
    CLS_ALU_IMM = 2'b10,
    CLS_CTRL    = 2'b11
  } class_e;

  localparam logic [4:0] SUB_NOP  = 5'd0;
  localparam logic [4:0] SUB_LD   = 5'd0;
  localparam logic [4:0] SUB_ST   = 5'd1;
  localparam logic [4:0] SUB_BZ   = 5'd2;
  localparam logic [4:0] SUB_JMP  = 5'd3;
  localparam logic [4:0] SUB_HALT = 5'd4;

  localparam logic [4:0] FS_PASS_A = 5'd0;

  typedef struct packed {
    logic [4:0] da;
    logic [4:0] aa;
    logic [4:0] ba;
    logic       mb;
    logic       md;
    logic [4:0] fs;
    logic       rw;
    logic       mw;
  } ctrl_word_t;

  function automatic logic [INSTR_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [INSTR_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSTR_W-IMM_W){1'b0}}, imm};
  endfunction

  function automatic logic is_legal(input logic [1:0] cls, input logic [4:0] sub);
    case (cls)
      CLS_MISC: return sub == SUB_NOP;
      CLS_CTRL: return sub <= SUB_HALT;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational decode of the registered instruction and FSM state into the
// datapath control word. DATAPATH_SEQ_IMM_SIGN_EXT_EN sign-extends ALU/LD/ST immediates.
module seq_decode
  import datapath_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  input  state_e             state_i,
  input  logic               mem_ready_i,
  output ctrl_word_t         ctrl_o,
  output logic [INSTR_W-1:0] constant_o
);

  logic [1:0]         cls;
  logic [4:0]         sub;
  logic [INSTR_W-1:0] imm_data;
  logic               active;

  assign cls    = ir_i[31:30];
  assign sub    = ir_i[29:25];
  assign active = (state_i == ST_DECODE) || (state_i == ST_EXEC) || (state_i == ST_MEM);

`ifdef DATAPATH_SEQ_IMM_SIGN_EXT_EN
  assign imm_data = sext_imm(ir_i[14:0]);
`else
  assign imm_data = zext_imm(ir_i[14:0]);
`endif

  // NOTE: every output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    ctrl_o     = '0;
    constant_o = '0;
    if (active) begin
      unique case (class_e'(cls))
        CLS_ALU_REG: begin
          ctrl_o.da  = ir_i[24:20];
          ctrl_o.aa  = ir_i[19:15];
          ctrl_o.ba  = ir_i[14:10];
          ctrl_o.mb  = 1'b1;
          ctrl_o.fs  = sub;
          ctrl_o.rw  = (state_i == ST_EXEC);
          constant_o = zext_imm(ir_i[14:0]);
        end
        CLS_ALU_IMM: begin
          ctrl_o.da  = ir_i[24:20];
          ctrl_o.aa  = ir_i[19:15];
          ctrl_o.fs  = sub;
          ctrl_o.rw  = (state_i == ST_EXEC);
          constant_o = imm_data;
        end
        CLS_CTRL: begin
          case (sub)
            SUB_LD: begin
              ctrl_o.da  = ir_i[24:20];
              ctrl_o.aa  = ir_i[19:15];
              ctrl_o.rw  = (state_i == ST_MEM) && mem_ready_i;
              ctrl_o.md  = (state_i == ST_MEM) && mem_ready_i;
              constant_o = imm_data;
            end
            SUB_ST: begin
              ctrl_o.aa  = ir_i[19:15];
              ctrl_o.ba  = ir_i[14:10];
              ctrl_o.mb  = 1'b1;
              ctrl_o.mw  = (state_i == ST_MEM);
              constant_o = imm_data;
            end
            SUB_BZ: begin
              ctrl_o.aa  = ir_i[19:15];
              ctrl_o.fs  = FS_PASS_A;
              constant_o = sext_imm(ir_i[14:0]);
            end
            SUB_JMP: constant_o = zext_imm(ir_i[14:0]);
            default: ;
          endcase
        end
        CLS_MISC: ;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer: fetch/decode/exec/mem FSM, program counter and instruction
// register. Build option DATAPATH_SEQ_IMM_SIGN_EXT_EN is handled in seq_decode.
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 5,
  parameter int                FS_W     = 5,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              zero_in,
  output logic [DATA_W-1:0] pc,
  output logic [REG_AW-1:0] DA,
  output logic [REG_AW-1:0] AA,
  output logic [REG_AW-1:0] BA,
  output logic              MB,
  output logic              MD,
  output logic [FS_W-1:0]   FS,
  output logic              RW,
  output logic              MW,
  output logic [DATA_W-1:0] constant_out,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               illegal_q, illegal_d;
  logic [1:0]         ir_cls;
  logic [4:0]         ir_sub;
  ctrl_word_t         ctrl;
  logic [INSTR_W-1:0] constant;

  assign ir_cls = ir_q[31:30];
  assign ir_sub = ir_q[29:25];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    illegal_d    = illegal_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata[INSTR_W-1:0];
          pc_d    = pc_q + DATA_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!is_legal(ir_cls, ir_sub)) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (ir_cls == CLS_CTRL) begin
          case (ir_sub)
            SUB_LD, SUB_ST: state_d = ST_MEM;
            SUB_BZ: begin
              // Offset applies to the already-incremented pc, i.e. the next instruction.
              if (zero_in) pc_d = pc_q + DATA_W'(sext_imm(ir_q[14:0]));
              state_d = ST_FETCH;
            end
            SUB_JMP: begin
              pc_d    = DATA_W'(zext_imm(ir_q[14:0]));
              state_d = ST_FETCH;
            end
            default: state_d = ST_HALT;
          endcase
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (ir_sub == SUB_ST);
        if (mem_ready) state_d = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  seq_decode u_decode (
    .ir_i        (ir_q),
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl),
    .constant_o  (constant)
  );

  assign pc           = pc_q;
  assign DA           = REG_AW'(ctrl.da);
  assign AA           = REG_AW'(ctrl.aa);
  assign BA           = REG_AW'(ctrl.ba);
  assign MB           = ctrl.mb;
  assign MD           = ctrl.md;
  assign FS           = FS_W'(ctrl.fs);
  assign RW           = ctrl.rw;
  assign MW           = ctrl.mw;
  assign constant_out = DATA_W'(constant);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted       = (state_q == ST_HALT);
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench: directed scenarios plus a random instruction stream scored
// against an instruction-level model of pc and control-pulse behaviour.
module tb_datapath_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, start, mem_ready, zero_in;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [31:0] pc, constant_out;
  logic [4:0]  DA, AA, BA, FS;
  logic        MB, MD, RW, MW, busy, halted, illegal;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc;

  typedef struct {
    int          rw_cnt;
    logic [4:0]  rw_da;
    logic        rw_md;
    logic        rw_ready;
    logic [4:0]  rw_fs;
    logic        rw_mb;
    logic [31:0] rw_const;
    int          mw_cnt;
    logic [4:0]  mw_ba;
    logic        mw_mb;
    int          dcycles;
    logic        we_any;
    logic        timeout;
    logic        halted;
  } obs_t;

  datapath_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .zero_in(zero_in),
    .pc(pc), .DA(DA), .AA(AA), .BA(BA), .MB(MB), .MD(MD), .FS(FS),
    .RW(RW), .MW(MW), .constant_out(constant_out),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; zero_in = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] cls, input logic [4:0] sub,
                                     input logic [4:0] dr, input logic [4:0] sa,
                                     input logic [14:0] imm);
    return {cls, sub, dr, sa, imm};
  endfunction

  // Architectural next-pc rule for one retired instruction.
  function automatic logic [31:0] model_pc(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic z);
    logic [31:0] nxt;
    logic [31:0] off;
    nxt = cur + 32'd1;
    off = {{17{ins[14]}}, ins[14:0]};
    if (ins[31:30] == 2'b11 && ins[29:25] == 5'd2 && z) return nxt + off;
    if (ins[31:30] == 2'b11 && ins[29:25] == 5'd3) return {17'd0, ins[14:0]};
    return nxt;
  endfunction

  // Plays memory for one instruction starting in FETCH; stops at the next fetch or HALT.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw,
                           input logic z, output obs_t o);
    int waited;
    o = '{default: 0};
    waited = 0;
    zero_in = z;
    repeat (fw) begin mem_ready = 1'b0; step(); end
    mem_rdata = ins; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    o.timeout = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (halted) begin o.halted = 1'b1; o.timeout = 1'b0; break; end
      if (mem_req && !mem_addr_sel) begin o.timeout = 1'b0; break; end
      mem_rdata = $urandom;
      if (mem_req && mem_addr_sel) begin
        mem_ready = (waited == dw);
        waited++;
        o.dcycles++;
        if (mem_we) o.we_any = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (RW) begin
        o.rw_cnt++; o.rw_da = DA; o.rw_md = MD; o.rw_ready = mem_ready;
        o.rw_fs = FS; o.rw_mb = MB; o.rw_const = constant_out;
      end
      if (MW) begin o.mw_cnt++; o.mw_ba = BA; o.mw_mb = MB; end
      step();
      mem_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [82:0] outs;
    do_reset();
    outs = {mem_req, mem_we, mem_addr_sel, DA, AA, BA, MB, MD, FS, RW, MW,
            constant_out, busy, halted, illegal};
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    mem_ready = 1'b1;
    repeat (2) step();
    mem_ready = 1'b0;
    checks++; if ({busy, mem_req} !== 2'b00) begin errors++; $display("FAIL idle_ignores_ready: busy/req got %b expected 00", {busy, mem_req}); end
    exp_pc = RESET_PC;
  endtask

  task automatic test_start();
    pulse_start();
    checks++; if ({mem_req, mem_addr_sel, mem_we, busy} !== 4'b1001) begin errors++; $display("FAIL start_fetch: req/sel/we/busy got %b expected 1001", {mem_req, mem_addr_sel, mem_we, busy}); end
  endtask

  task automatic test_alu_imm();
    logic [31:0] ins;
    logic [4:0]  dr;
    ins = 32'h84A0_0005;
    dr  = ins[24:20];
    mem_rdata = ins; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++; if ({DA, constant_out, RW} !== {dr, 32'd5, 1'b0}) begin errors++; $display("FAIL alu_decode: DA/const/RW got %h/%h/%b expected %h/5/0", DA, constant_out, RW, dr); end
    checks++; if (pc !== RESET_PC + 32'd1) begin errors++; $display("FAIL alu_pc: got %h expected %h", pc, RESET_PC + 32'd1); end
    step();
    checks++; if ({FS, MB, constant_out, DA, RW, MD} !== {5'd2, 1'b0, 32'd5, dr, 1'b1, 1'b0}) begin errors++; $display("FAIL alu_exec: FS/MB/const/DA/RW/MD got %h/%b/%h/%h/%b/%b expected 2/0/5/%h/1/0", FS, MB, constant_out, DA, RW, MD, dr); end
    step();
    checks++; if ({RW, mem_req, mem_addr_sel} !== 3'b010) begin errors++; $display("FAIL alu_back_to_fetch: RW/req/sel got %b expected 010", {RW, mem_req, mem_addr_sel}); end
    exp_pc = RESET_PC + 32'd1;
  endtask

  task automatic test_ld_wait();
    obs_t o;
    run_instr(mk(2'b11, 5'd0, 5'd3, 5'd7, 15'd0), 1, 3, 1'b0, o);
    exp_pc = exp_pc + 32'd1;
    checks++; if (o.timeout !== 1'b0) begin errors++; $display("FAIL ld_timeout: got %b expected 0", o.timeout); end
    checks++; if (o.dcycles !== 4) begin errors++; $display("FAIL ld_req_cycles: got %0d expected 4", o.dcycles); end
    checks++; if ({o.rw_cnt == 1, o.rw_md, o.rw_ready, o.rw_da} !== {3'b111, 5'd3}) begin errors++; $display("FAIL ld_writeback: cnt=%0d md=%b ready=%b da=%h expected 1/1/1/03", o.rw_cnt, o.rw_md, o.rw_ready, o.rw_da); end
    checks++; if ({o.we_any, o.mw_cnt == 0} !== 2'b01) begin errors++; $display("FAIL ld_no_write: we=%b mw_cnt=%0d expected 0/0", o.we_any, o.mw_cnt); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL ld_pc: got %h expected %h", pc, exp_pc); end
  endtask

  task automatic test_st();
    obs_t o;
    run_instr(mk(2'b11, 5'd1, 5'd0, 5'd2, {5'd9, 10'd0}), 0, 2, 1'b0, o);
    exp_pc = exp_pc + 32'd1;
    checks++; if ({o.mw_cnt == 3, o.dcycles == 3, o.we_any, o.mw_mb} !== 4'b1111) begin errors++; $display("FAIL st_write: mw_cnt=%0d req=%0d we=%b mb=%b expected 3/3/1/1", o.mw_cnt, o.dcycles, o.we_any, o.mw_mb); end
    checks++; if ({o.mw_ba, o.rw_cnt == 0} !== {5'd9, 1'b1}) begin errors++; $display("FAIL st_ba_rw: ba=%h rw_cnt=%0d expected 09/0", o.mw_ba, o.rw_cnt); end
  endtask

  task automatic test_bz();
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      run_instr(mk(2'b11, 5'd3, 5'd0, 5'd0, 15'h0010), 0, 0, 1'b0, o);
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL jmp_target[%0d]: got %h expected 00000010", k, pc); end
      run_instr(mk(2'b11, 5'd2, 5'd0, 5'd4, 15'h7FFE), 1, 0, (k == 0), o);
      exp_pc = (k == 0) ? 32'h0F : 32'h11;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL bz_pc[z=%0d]: got %h expected %h", (k == 0), pc, exp_pc); end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [31:0] ins;
    logic [1:0]  cls;
    logic [4:0]  sub;
    logic [31:0] exp_const;
    int          kind, dw;
    logic        z, is_alu, is_ld, is_st;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin cls = 2'b01; sub = 5'($urandom); end
        1: begin cls = 2'b10; sub = 5'($urandom); end
        2: begin cls = 2'b11; sub = 5'd0; end
        3: begin cls = 2'b11; sub = 5'd1; end
        4: begin cls = 2'b11; sub = 5'd2; end
        5: begin cls = 2'b11; sub = 5'd3; end
        default: begin cls = 2'b00; sub = 5'd0; end
      endcase
      ins = {cls, sub, 25'($urandom)};
      dw  = $urandom_range(0, 3);
      z   = 1'($urandom_range(0, 1));
`ifdef DATAPATH_SEQ_IMM_SIGN_EXT_EN
      exp_const = {{17{ins[14]}}, ins[14:0]};
`else
      exp_const = {17'd0, ins[14:0]};
`endif
      run_instr(ins, $urandom_range(0, 3), dw, z, o);
      exp_pc = model_pc(exp_pc, ins, z);
      is_alu = (kind < 2); is_ld = (kind == 2); is_st = (kind == 3);
      checks++; if ({o.timeout, o.halted} !== 2'b00) begin errors++; $display("FAIL rnd_flow[%0d]: timeout/halt got %b expected 00 ins=%h", i, {o.timeout, o.halted}, ins); end
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h ins=%h", i, pc, exp_pc, ins); end
      checks++; if (o.rw_cnt !== ((is_alu || is_ld) ? 1 : 0)) begin errors++; $display("FAIL rnd_rw_cnt[%0d]: got %0d ins=%h", i, o.rw_cnt, ins); end
      checks++; if (o.mw_cnt !== (is_st ? dw + 1 : 0)) begin errors++; $display("FAIL rnd_mw_cnt[%0d]: got %0d ins=%h", i, o.mw_cnt, ins); end
      checks++; if (o.dcycles !== ((is_ld || is_st) ? dw + 1 : 0) || o.we_any !== is_st) begin errors++; $display("FAIL rnd_dmem[%0d]: cycles=%0d we=%b ins=%h dw=%0d", i, o.dcycles, o.we_any, ins, dw); end
      if (is_alu || is_ld) begin
        checks++; if ({o.rw_da, o.rw_md} !== {ins[24:20], is_ld}) begin errors++; $display("FAIL rnd_wb[%0d]: da/md got %h/%b expected %h/%b", i, o.rw_da, o.rw_md, ins[24:20], is_ld); end
      end
      if (is_alu) begin
        checks++; if ({o.rw_fs, o.rw_mb} !== {sub, (cls == 2'b01)}) begin errors++; $display("FAIL rnd_alu[%0d]: fs/mb got %h/%b expected %h/%b", i, o.rw_fs, o.rw_mb, sub, (cls == 2'b01)); end
        if (cls == 2'b10) begin
          checks++; if (o.rw_const !== exp_const) begin errors++; $display("FAIL rnd_imm[%0d]: got %h expected %h", i, o.rw_const, exp_const); end
        end
      end
      if (is_st) begin
        checks++; if ({o.mw_ba, o.mw_mb} !== {ins[14:10], 1'b1}) begin errors++; $display("FAIL rnd_st[%0d]: ba/mb got %h/%b expected %h/1", i, o.mw_ba, o.mw_mb, ins[14:10]); end
      end
    end
  endtask

  task automatic test_halt();
    obs_t o;
    do_reset();
    pulse_start();
    run_instr(32'hC800_0000, 0, 0, 1'b0, o);
    checks++; if ({o.halted, halted, illegal, busy} !== 4'b1100) begin errors++; $display("FAIL halt_legal: seen/halted/illegal/busy got %b expected 1100", {o.halted, halted, illegal, busy}); end
  endtask

  task automatic test_illegal();
    obs_t o;
    do_reset();
    pulse_start();
    run_instr(32'hFE00_0000, 0, 0, 1'b0, o);
    checks++; if ({o.halted, halted, illegal, busy} !== 4'b1110) begin errors++; $display("FAIL illegal_halt: seen/halted/illegal/busy got %b expected 1110", {o.halted, halted, illegal, busy}); end
    pulse_start();
    repeat (3) step();
    checks++; if ({halted, illegal, busy, mem_req} !== 4'b1100) begin errors++; $display("FAIL halt_ignores_start: halted/illegal/busy/req got %b expected 1100", {halted, illegal, busy, mem_req}); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    pulse_start();
    mem_rdata = mk(2'b11, 5'd0, 5'd1, 5'd2, 15'd0); mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    repeat (2) step();
    checks++; if ({mem_req, mem_addr_sel} !== 2'b11) begin errors++; $display("FAIL mem_entered: req/sel got %b expected 11", {mem_req, mem_addr_sel}); end
    reset = 1'b1; mem_ready = 1'b1;
    step();
    checks++; if ({mem_req, busy, RW, pc} !== {3'b000, RESET_PC}) begin errors++; $display("FAIL reset_mid_mem: req/busy/RW got %b pc %h expected 000 pc %h", {mem_req, busy, RW}, pc, RESET_PC); end
    reset = 1'b0;
    step();
    mem_ready = 1'b0;
    checks++; if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL after_reset_idle: req/busy got %b expected 00", {mem_req, busy}); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_alu_imm();
    test_ld_wait();
    test_st();
    test_bz();
    test_random();
    test_halt();
    test_illegal();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
